// File: rtl/pipeline_writeback.sv
// Writeback stage: result select, optional load extraction, registered regfile write, precise trap record, retire counter.
// Optional feature macro: PIPELINE_WB_LOAD_EXTEND_EN (sub-word load extraction with sign/zero fill).
module pipeline_writeback #(
    parameter int DATA_W    = 32,
    parameter int REG_IDX_W = 5,
    parameter int CNT_W     = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic [DATA_W-1:0]    pc,
    input  logic                 decode_exception,
    input  logic [2:0]           alu_exception,
    input  logic [2:0]           mem_exception,
    input  logic [REG_IDX_W-1:0] rd_index,
    input  logic                 regwrite_enable,
    input  logic                 memread_enable,
    input  logic                 memop_disable,
    input  logic [1:0]           mem_size,
    input  logic                 mem_signed,
    input  logic [1:0]           mem_addr_lo,
    input  logic [DATA_W-1:0]    alu_out,
    input  logic [DATA_W-1:0]    mem_out,
    output logic                 we,
    output logic [REG_IDX_W-1:0] windex,
    output logic [DATA_W-1:0]    win,
    output logic                 exc_valid,
    output logic [6:0]           exc_code,
    output logic [DATA_W-1:0]    exc_pc,
    input  logic                 exc_ack,
    output logic [CNT_W-1:0]     retire_count
);

    typedef enum logic {RUN = 1'b0, TRAP = 1'b1} state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [6:0]             w_exc;
    logic                   w_take_trap;
    logic                   w_accept_p0;
    logic                   w_do_write_p0;
    logic [DATA_W-1:0]      w_mem_val_p0;
    logic [DATA_W-1:0]      w_result_p0;

    logic                   r_we_p1;
    logic [REG_IDX_W-1:0]   r_windex_p1;
    logic [DATA_W-1:0]      r_win_p1;
    logic [6:0]             r_exc_code;
    logic [DATA_W-1:0]      r_exc_pc;
    logic [CNT_W-1:0]       r_retire_cnt;

`ifdef PIPELINE_WB_LOAD_EXTEND_EN
    function automatic logic [DATA_W-1:0] load_extend(
        input logic [DATA_W-1:0] raw,
        input logic [1:0]        size,
        input logic              sgn,
        input logic [1:0]        lo
    );
        logic [31:0]       sh;
        logic [DATA_W-1:0] res;
        res = raw;
        sh  = raw[31:0];
        case (size)
            2'b00: begin
                sh  = raw[31:0] >> {lo, 3'b000};
                res = {{(DATA_W-8){sgn & sh[7]}}, sh[7:0]};
            end
            2'b01: begin
                sh  = raw[31:0] >> {lo[1], 4'b0000};
                res = {{(DATA_W-16){sgn & sh[15]}}, sh[15:0]};
            end
            default: res = raw;
        endcase
        return res;
    endfunction

    assign w_mem_val_p0 = load_extend(mem_out, mem_size, mem_signed, mem_addr_lo);
`else
    logic w_unused_load;
    assign w_unused_load = ^{mem_size, mem_signed, mem_addr_lo};
    assign w_mem_val_p0  = mem_out;
`endif

    assign w_exc         = {decode_exception, alu_exception, mem_exception};
    assign w_take_trap   = in_valid && (r_state == RUN) && (w_exc != 7'd0);
    assign w_accept_p0   = in_valid && (r_state == RUN) && (w_exc == 7'd0);
    assign w_do_write_p0 = w_accept_p0 && regwrite_enable && (rd_index != '0);
    assign w_result_p0   = (memread_enable && !memop_disable) ? w_mem_val_p0 : alu_out;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            RUN:  if (w_take_trap) w_state_nxt = TRAP;
            TRAP: if (exc_ack)     w_state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // p0 -> p1: acceptance edge; write port and trap record are registered here
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we_p1      <= 1'b0;
            r_windex_p1  <= '0;
            r_win_p1     <= '0;
            r_exc_code   <= '0;
            r_exc_pc     <= '0;
            r_retire_cnt <= '0;
        end else begin
            r_we_p1 <= w_do_write_p0;
            if (w_do_write_p0) begin
                r_windex_p1 <= rd_index;
                r_win_p1    <= w_result_p0;
            end
            if (w_take_trap) begin
                r_exc_code <= w_exc;
                r_exc_pc   <= pc;
            end
            if (w_accept_p0) begin
                r_retire_cnt <= r_retire_cnt + CNT_W'(1);
            end
        end
    end

    assign we           = r_we_p1;
    assign windex       = r_windex_p1;
    assign win          = r_win_p1;
    assign exc_valid    = (r_state == TRAP);
    assign exc_code     = r_exc_code;
    assign exc_pc       = r_exc_pc;
    assign retire_count = r_retire_cnt;

endmodule
